// File: rtl/fifo_rd_drain_pkg.sv
// Shared types and constants for the FIFO read-drain block and its skid buffer.
package fifo_rd_drain_pkg;

    localparam int SKID_DP = 2;
    localparam int CNT_W   = 9;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_e;

    // A burst_len field of 0 stands for a full 256-word burst.
    function automatic logic [CNT_W-1:0] burst_words(input logic [7:0] len);
        return (len == 8'd0) ? CNT_W'(256) : {1'b0, len};
    endfunction

endpackage

// File: rtl/stream_skid2.sv
// Two-entry first-in first-out skid buffer with a valid/ready read side and an occupancy output.
module stream_skid2
    import fifo_rd_drain_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_en_i,
    input  logic [W-1:0] wr_data_i,
    output logic         valid_o,
    input  logic         ready_i,
    output logic [W-1:0] data_o,
    output logic [1:0]   occ_o
);

    logic [W-1:0] mem_q [SKID_DP];
    logic         rd_ptr_q;
    logic         wr_ptr_q;
    logic [1:0]   occ_q;
    logic [1:0]   occ_d;
    logic         pop;
    logic         push;

    assign pop  = valid_o & ready_i;
    // A write into a full buffer is only legal when the head leaves in the same cycle.
    assign push = wr_en_i & ((occ_q != 2'd2) | pop);

    always_comb begin
        occ_d = occ_q + 2'(push) - 2'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            occ_q    <= 2'd0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= wr_data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            occ_q <= occ_d;
        end
    end

    assign valid_o = (occ_q != 2'd0);
    assign data_o  = mem_q[rd_ptr_q];
    assign occ_o   = occ_q;

endmodule

// File: rtl/fifo_rd_drain.sv
// Pops a burst of words from a FIFO and presents them as a valid/ready stream with last and done.
module fifo_rd_drain
    import fifo_rd_drain_pkg::*;
#(
    parameter int W      = 8,
    parameter int RD_LAT = 0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [7:0]   burst_len,
    input  logic         fifo_empty,
    output logic         fifo_rd_en,
    input  logic [W-1:0] fifo_rd_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic [W-1:0] m_data,
    output logic         m_last,
    output logic         busy,
    output logic         done,
    output state_e       dbg_state_o
);

    // Stream handshake: a word moves when m_valid & m_ready at a rising edge; once
    // m_valid is raised, m_valid and m_data hold until that handshake happens.

    state_e           state_q;
    logic [CNT_W-1:0] pop_rem_q;
    logic [CNT_W-1:0] xfer_rem_q;
    logic             busy_q;
    logic             done_q;
    logic             inflight_q;
    logic [1:0]       occ;
    logic [2:0]       pending;
    logic             skid_wr;
    logic             hs;

    // Pops are throttled so skid entries plus words still in flight never exceed two.
    assign pending    = {1'b0, occ} + {2'b00, inflight_q};
    assign fifo_rd_en = (state_q == RUN) & ~fifo_empty & (pop_rem_q != '0) & (pending < 3'd2);
    assign hs         = m_valid & m_ready;
    assign skid_wr    = (RD_LAT != 0) ? inflight_q : fifo_rd_en;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= (RD_LAT != 0) & fifo_rd_en;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            pop_rem_q  <= '0;
            xfer_rem_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (fifo_rd_en) begin
                pop_rem_q <= pop_rem_q - CNT_W'(1);
            end
            if (hs) begin
                xfer_rem_q <= xfer_rem_q - CNT_W'(1);
            end
            case (state_q)
                IDLE: begin
                    // A start landing on the done cycle is dropped.
                    if (start && !done_q) begin
                        state_q    <= RUN;
                        pop_rem_q  <= burst_words(burst_len);
                        xfer_rem_q <= burst_words(burst_len);
                        busy_q     <= 1'b1;
                    end
                end
                RUN: begin
                    if (fifo_rd_en && (pop_rem_q == CNT_W'(1))) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (hs && (xfer_rem_q == CNT_W'(1))) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    stream_skid2 #(
        .W(W)
    ) u_skid (
        .clk       (clk),
        .rst       (reset),
        .wr_en_i   (skid_wr),
        .wr_data_i (fifo_rd_data),
        .valid_o   (m_valid),
        .ready_i   (m_ready),
        .data_o    (m_data),
        .occ_o     (occ)
    );

    assign m_last      = m_valid & (xfer_rem_q == CNT_W'(1));
    assign busy        = busy_q;
    assign done        = done_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fifo_rd_drain.sv
// Bench driving one RD_LAT=0 and one RD_LAT=1 instance from a shared word stream and shared controls.
module tb_fifo_rd_drain;
    import fifo_rd_drain_pkg::*;

    localparam int W     = 8;
    localparam int PAT_N = 2048;

    logic         clk        = 1'b0;
    logic         reset      = 1'b1;
    logic         start      = 1'b0;
    logic [7:0]   burst_len  = 8'd0;
    logic         m_ready    = 1'b0;
    logic         hold_empty = 1'b0;
    int           avail      = 0;
    logic [W-1:0] pat [PAT_N];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Each lane sees the FIFO as the shared word stream pat[pop_idx .. avail-1];
    // the stream it delivers must be that same sequence, chunked into bursts.
    for (genvar g = 0; g < 2; g++) begin : lane
        logic         fifo_empty, fifo_rd_en, m_valid, m_last, busy, done;
        logic [W-1:0] fifo_rd_data, m_data;
        logic [W-1:0] lat_data   = '0;
        logic [W-1:0] stall_data = '0;
        state_e       dbg_state;
        int           pop_idx = 0, hs_idx = 0, burst_n = 0, burst_pops = 0, burst_hs = 0;
        int           pops_total = 0, hs_total = 0, done_cnt = 0;
        logic         exp_busy = 1'b0, exp_done = 1'b0, stalled = 1'b0;

        assign fifo_empty   = hold_empty || (pop_idx >= avail);
        assign fifo_rd_data = (g == 0) ? pat[pop_idx % PAT_N] : lat_data;

        fifo_rd_drain #(.W(W), .RD_LAT(g)) dut (
            .clk          (clk),
            .reset        (reset),
            .start        (start),
            .burst_len    (burst_len),
            .fifo_empty   (fifo_empty),
            .fifo_rd_en   (fifo_rd_en),
            .fifo_rd_data (fifo_rd_data),
            .m_valid      (m_valid),
            .m_ready      (m_ready),
            .m_data       (m_data),
            .m_last       (m_last),
            .busy         (busy),
            .done         (done),
            .dbg_state_o  (dbg_state)
        );

        always @(posedge clk) begin
            if (reset) begin
                exp_busy   <= 1'b0;
                exp_done   <= 1'b0;
                stalled    <= 1'b0;
                hs_idx     <= pop_idx;
                burst_hs   <= 0;
                burst_pops <= 0;
            end else begin
                exp_done   <= 1'b0;
                stalled    <= m_valid && !m_ready;
                stall_data <= m_data;
                if (start && !exp_busy && !exp_done) begin
                    burst_n    <= (burst_len == 8'd0) ? 256 : int'(burst_len);
                    burst_pops <= 0;
                    burst_hs   <= 0;
                    exp_busy   <= 1'b1;
                end
                if (fifo_rd_en) begin
                    pop_idx    <= pop_idx + 1;
                    burst_pops <= burst_pops + 1;
                    pops_total <= pops_total + 1;
                    lat_data   <= pat[pop_idx % PAT_N];
                end
                if (m_valid && m_ready) begin
                    hs_idx   <= hs_idx + 1;
                    burst_hs <= burst_hs + 1;
                    hs_total <= hs_total + 1;
                    if (burst_hs + 1 == burst_n) begin
                        exp_busy <= 1'b0;
                        exp_done <= 1'b1;
                    end
                end
            end
        end

        always @(negedge clk) begin
            if (!reset) begin
                if (done) done_cnt = done_cnt + 1;
                check($sformatf("lat%0d_busy", g), 32'(busy), 32'(exp_busy));
                check($sformatf("lat%0d_done", g), 32'(done), 32'(exp_done));
                if (fifo_rd_en) begin
                    check($sformatf("lat%0d_pop_while_empty", g), 32'(fifo_empty), 32'(0));
                    check($sformatf("lat%0d_pop_over_len", g), 32'(burst_pops < burst_n), 32'(1));
                end
                if (stalled) begin
                    check($sformatf("lat%0d_stall_valid", g), 32'(m_valid), 32'(1));
                    check($sformatf("lat%0d_stall_data", g), 32'(m_data), 32'(stall_data));
                end
                if (m_valid) begin
                    check($sformatf("lat%0d_m_data", g), 32'(m_data), 32'(pat[hs_idx % PAT_N]));
                    check($sformatf("lat%0d_m_last", g), 32'(m_last), 32'(burst_hs == burst_n - 1));
                    check($sformatf("lat%0d_valid_src", g), 32'(hs_idx < pop_idx), 32'(1));
                    check($sformatf("lat%0d_valid_busy", g), 32'(exp_busy), 32'(1));
                end else begin
                    check($sformatf("lat%0d_m_last_low", g), 32'(m_last), 32'(0));
                end
                if (exp_done) begin
                    check($sformatf("lat%0d_burst_pops", g), 32'(burst_pops), 32'(burst_n));
                end
            end
        end
    end

    task automatic check_reset_vals(input string tag);
        check({tag, "_outs0"}, 32'({lane[0].fifo_rd_en, lane[0].m_valid, lane[0].m_last, lane[0].busy, lane[0].done}), 32'(0));
        check({tag, "_data0"}, 32'(lane[0].m_data), 32'(0));
        check({tag, "_state0"}, 32'(lane[0].dbg_state), 32'(IDLE));
        check({tag, "_outs1"}, 32'({lane[1].fifo_rd_en, lane[1].m_valid, lane[1].m_last, lane[1].busy, lane[1].done}), 32'(0));
        check({tag, "_data1"}, 32'(lane[1].m_data), 32'(0));
        check({tag, "_state1"}, 32'(lane[1].dbg_state), 32'(IDLE));
    endtask

    task automatic pulse_start(input int len);
        start     = 1'b1;
        burst_len = 8'(len);
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n = 0;
        while ((lane[0].exp_busy || lane[1].exp_busy) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_timeout"}, 32'(n < budget), 32'(1));
        @(negedge clk);
    endtask

    int p0, p1, h0, h1, d0, d1;

    task automatic snap();
        p0 = lane[0].pops_total; p1 = lane[1].pops_total;
        h0 = lane[0].hs_total;   h1 = lane[1].hs_total;
        d0 = lane[0].done_cnt;   d1 = lane[1].done_cnt;
    endtask

    task automatic check_deltas(input string tag, input int pops, input int hs, input int dn);
        check({tag, "_pops0"}, 32'(lane[0].pops_total - p0), 32'(pops));
        check({tag, "_pops1"}, 32'(lane[1].pops_total - p1), 32'(pops));
        check({tag, "_hs0"}, 32'(lane[0].hs_total - h0), 32'(hs));
        check({tag, "_hs1"}, 32'(lane[1].hs_total - h1), 32'(hs));
        check({tag, "_done0"}, 32'(lane[0].done_cnt - d0), 32'(dn));
        check({tag, "_done1"}, 32'(lane[1].done_cnt - d1), 32'(dn));
    endtask

    initial begin
        int first0, first1, done_at0, n, len;
        for (int i = 0; i < PAT_N; i++) pat[i] = W'($urandom_range(0, 255));

        // Reset state
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        reset = 1'b0;
        @(negedge clk);

        // Four queued words, sink always ready: latency, back-to-back delivery, done timing
        avail += 4;
        m_ready = 1'b1;
        snap();
        first0 = -1; first1 = -1; done_at0 = -1;
        start = 1'b1;
        burst_len = 8'd4;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            if (first0 < 0 && lane[0].m_valid) first0 = k;
            if (first1 < 0 && lane[1].m_valid) first1 = k;
            if (done_at0 < 0 && lane[0].done) done_at0 = k;
        end
        check("first_valid_lat0", 32'(first0), 32'(2));
        check("first_valid_lat1", 32'(first1), 32'(3));
        check("done_cycle_lat0", 32'(done_at0), 32'(6));
        check_deltas("burst4", 4, 4, 1);

        // Sink stalled for five cycles after start
        avail += 3;
        m_ready = 1'b0;
        snap();
        pulse_start(3);
        repeat (4) @(negedge clk);
        check("stall_pops_lat0", 32'(lane[0].pops_total - p0 <= 2), 32'(1));
        check("stall_pops_lat1", 32'(lane[1].pops_total - p1 <= 2), 32'(1));
        check("stall_no_hs0", 32'(lane[0].hs_total - h0), 32'(0));
        m_ready = 1'b1;
        wait_idle(100, "stall3");
        check_deltas("stall3", 3, 3, 1);

        // FIFO runs dry after two of five words and refills ten cycles later
        avail += 2;
        snap();
        pulse_start(5);
        repeat (10) @(negedge clk);
        check("dry_partial_pops0", 32'(lane[0].pops_total - p0), 32'(2));
        avail += 3;
        wait_idle(100, "dry5");
        check_deltas("dry5", 5, 5, 1);

        // burst_len 0 means 256 words
        avail += 256;
        snap();
        pulse_start(0);
        wait_idle(1500, "b256");
        check_deltas("b256", 256, 256, 1);
        check("b256_busy_low0", 32'(lane[0].busy), 32'(0));
        check("b256_busy_low1", 32'(lane[1].busy), 32'(0));

        // start held for three cycles: only the first is taken
        avail += 4;
        snap();
        start = 1'b1;
        burst_len = 8'd4;
        repeat (3) @(negedge clk);
        start = 1'b0;
        wait_idle(100, "held");
        check_deltas("held", 4, 4, 1);

        // start on the done cycle is dropped, start on the cycle after is taken (fast lane)
        avail += 6;
        snap();
        pulse_start(3);
        n = 0;
        while (!lane[0].exp_done && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("done_align_timeout", 32'(n < 100), 32'(1));
        start = 1'b1;
        burst_len = 8'd3;
        @(negedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_idle(100, "b2b");
        check("b2b_done0", 32'(lane[0].done_cnt - d0), 32'(2));
        check("b2b_hs0", 32'(lane[0].hs_total - h0), 32'(6));

        // Randomised bursts with random sink back-pressure and FIFO stalls
        for (int b = 0; b < 20; b++) begin
            len = $urandom_range(1, 12);
            avail += len + $urandom_range(0, 2);
            snap();
            m_ready = ($urandom_range(0, 3) != 0);
            pulse_start(len);
            n = 0;
            while ((lane[0].exp_busy || lane[1].exp_busy) && n < 400) begin
                m_ready    = ($urandom_range(0, 3) != 0);
                hold_empty = ($urandom_range(0, 4) == 0);
                @(negedge clk);
                n++;
            end
            hold_empty = 1'b0;
            m_ready    = 1'b1;
            wait_idle(100, "rand");
            check_deltas("rand", len, len, 1);
        end

        // Reset in the middle of a stalled burst, then a one-word burst
        avail += 6;
        m_ready = 1'b0;
        snap();
        pulse_start(6);
        repeat (8) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("midrst");
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        check("midrst_no_done0", 32'(lane[0].done_cnt - d0), 32'(0));
        check("midrst_no_done1", 32'(lane[1].done_cnt - d1), 32'(0));
        m_ready = 1'b1;
        @(negedge clk);
        snap();
        pulse_start(1);
        wait_idle(100, "after_rst");
        check_deltas("after_rst", 1, 1, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        n_errors++;
        $display("FAIL watchdog: observed no completion expected completion");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1, "watchdog expired");
    end

endmodule
